mbist_repair_dump: RTL and testbench

//  Reader side of the repair-address serial scan port. Drives scan_shift into a repair-address block and deserialises
//  its sdo stream, LSB first, into 16-bit slots. Presents each recovered repair address on a valid/ready port
//  (to the host/register bank) for fuse programming or diagnosis. Sits beside one repair-address block in the MBIST wrapper.

---
 rtl/mbist_pkg.sv | 24 ++
 rtl/mbist_sdo_deser.sv | 44 ++++
 rtl/mbist_repair_dump.sv | 162 ++++++++++++++++
 tb/tb_mbist_repair_dump.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mbist_pkg.sv
// rtl/mbist_pkg.sv - shared MBIST constants and repair-dump state encoding
package mbist_pkg;

    // Error limit of the repair-address source block; the dump reads this many slots.
    localparam int BIST_ERR_LIMIT = 4;

    // Width of one slot in the source shift register.
    localparam int SLOT_WD_DEFAULT = 16;

    typedef enum logic [2:0] {
        DMP_IDLE,
        DMP_GAP,
        DMP_SHIFT,
        DMP_HOLD,
        DMP_FINISH,
        DMP_DONE
    } dump_state_t;

    // Counter width that stays legal (>= 1) when only one value is needed.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mbist_sdo_deser.sv
// rtl/mbist_sdo_deser.sv - LSB-first serial-to-slot deserialiser with bit counter
module mbist_sdo_deser
    import mbist_pkg::*;
#(
    parameter int SLOT_WD = SLOT_WD_DEFAULT,
    parameter int OUT_WD  = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              shift_en,
    input  logic              sdo,
    input  logic              clear,
    output logic              slot_done,
    output logic [OUT_WD-1:0] slot_next_lo,
    output logic [OUT_WD-1:0] slot_word_lo
);

    localparam int CNT_WD = cnt_width(SLOT_WD);
    localparam logic [CNT_WD-1:0] LAST_BIT = CNT_WD'(SLOT_WD - 1);

    logic [SLOT_WD-1:0] slot_word;
    logic [SLOT_WD-1:0] slot_next;
    logic [CNT_WD-1:0]  bit_cnt;

    // New bits enter at the top so the first sample ends up in bit 0.
    assign slot_next    = {sdo, slot_word[SLOT_WD-1:1]};
    assign slot_done    = shift_en && (bit_cnt == LAST_BIT);
    assign slot_next_lo = slot_next[OUT_WD-1:0];
    assign slot_word_lo = slot_word[OUT_WD-1:0];

    // Shift in one sample per enabled cycle; a clear drops any partial slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_word <= '0;
            bit_cnt   <= '0;
        end else if (clear) begin
            bit_cnt   <= '0;
        end else if (shift_en) begin
            slot_word <= slot_next;
            bit_cnt   <= slot_done ? '0 : bit_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mbist_repair_dump.sv
// rtl/mbist_repair_dump.sv - scan-port reader presenting repair addresses on valid/ready
module mbist_repair_dump
    import mbist_pkg::*;
#(
    parameter int NUM_WORDS = BIST_ERR_LIMIT,
    parameter int SLOT_WD   = SLOT_WD_DEFAULT,
    parameter int RAD_WD    = 9,
    parameter int GAP_CYC   = 1,
    parameter int IDX_WD    = cnt_width(NUM_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              scan_shift,
    output logic              scan_sdi,
    input  logic              scan_sdo,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [RAD_WD-1:0] word_data,
    output logic [IDX_WD-1:0] word_idx,
    output logic              word_last
);

    localparam int GAP_WD = cnt_width(GAP_CYC);
    localparam logic [GAP_WD-1:0] GAP_LAST  = GAP_WD'(GAP_CYC - 1);
    localparam logic [IDX_WD-1:0] SLOT_LAST = IDX_WD'(NUM_WORDS - 1);

    dump_state_t       state, state_nxt;
    logic [GAP_WD-1:0] gap_cnt;
    logic [IDX_WD-1:0] slot_cnt;
    logic              slot_done;
    logic [RAD_WD-1:0] slot_next_lo;
    logic [RAD_WD-1:0] slot_word_lo;
    logic              out_free;
    logic              last_slot;
    logic              load;
    logic              load_from_hold;
    logic [RAD_WD-1:0] load_data;

    mbist_sdo_deser #(
        .SLOT_WD (SLOT_WD),
        .OUT_WD  (RAD_WD)
    ) u_deser (
        .clk          (clk),
        .rst_n        (rst_n),
        .shift_en     (scan_shift),
        .sdo          (scan_sdo),
        .clear        (abort),
        .slot_done    (slot_done),
        .slot_next_lo (slot_next_lo),
        .slot_word_lo (slot_word_lo)
    );

    assign out_free   = !word_valid || word_ready;
    assign last_slot  = (slot_cnt == SLOT_LAST);
    assign busy       = (state != DMP_IDLE);
    assign done       = (state == DMP_DONE);
    assign scan_shift = (state == DMP_SHIFT);
    // Recirculate so the source shift register ends each slot holding its original value.
    assign scan_sdi   = scan_shift & scan_sdo;
    assign load_data  = load_from_hold ? slot_word_lo : slot_next_lo;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= DMP_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and output-register load; abort overrides everything.
    always_comb begin
        state_nxt      = state;
        load           = 1'b0;
        load_from_hold = 1'b0;
        case (state)
            DMP_IDLE: begin
                if (start) state_nxt = DMP_GAP;
            end
            DMP_GAP: begin
                if (gap_cnt == GAP_LAST) state_nxt = DMP_SHIFT;
            end
            DMP_SHIFT: begin
                if (slot_done) begin
                    if (out_free) begin
                        load      = 1'b1;
                        state_nxt = last_slot ? DMP_FINISH : DMP_GAP;
                    end else begin
                        state_nxt = DMP_HOLD;
                    end
                end
            end
            DMP_HOLD: begin
                if (out_free) begin
                    load           = 1'b1;
                    load_from_hold = 1'b1;
                    state_nxt      = last_slot ? DMP_FINISH : DMP_GAP;
                end
            end
            DMP_FINISH: begin
                if (word_valid && word_ready) state_nxt = DMP_DONE;
            end
            DMP_DONE: begin
                state_nxt = DMP_IDLE;
            end
            default: begin
                state_nxt = DMP_IDLE;
            end
        endcase
        if (abort) begin
            state_nxt      = DMP_IDLE;
            load           = 1'b0;
            load_from_hold = 1'b0;
        end
    end

    // Gap timer runs only while in GAP so each visit starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt <= '0;
        end else if (state != DMP_GAP || abort) begin
            gap_cnt <= '0;
        end else begin
            gap_cnt <= gap_cnt + 1'b1;
        end
    end

    // Slot index of the slot being shifted; saturates on the last slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt <= '0;
        end else if (state == DMP_IDLE || abort) begin
            slot_cnt <= '0;
        end else if (load && !last_slot) begin
            slot_cnt <= slot_cnt + 1'b1;
        end
    end

    // One-entry output register; contents frozen while valid and not accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_valid <= 1'b0;
            word_data  <= '0;
            word_idx   <= '0;
            word_last  <= 1'b0;
        end else if (abort) begin
            word_valid <= 1'b0;
        end else if (load) begin
            word_valid <= 1'b1;
            word_data  <= load_data;
            word_idx   <= slot_cnt;
            word_last  <= last_slot;
        end else if (word_valid && word_ready) begin
            word_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mbist_repair_dump.sv
// tb/tb_mbist_repair_dump.sv - randomized self-checking bench for mbist_repair_dump
module tb_mbist_repair_dump;

    localparam int NW = 4;
    localparam int SW = 16;
    localparam int RW = 9;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic          busy;
    logic          done;
    logic          scan_shift;
    logic          scan_sdi;
    logic          scan_sdo;
    logic          word_valid;
    logic          word_ready;
    logic [RW-1:0] word_data;
    logic [IW-1:0] word_idx;
    logic          word_last;

    always #5 clk = ~clk;

    mbist_repair_dump #(
        .NUM_WORDS (NW),
        .SLOT_WD   (SW),
        .RAD_WD    (RW),
        .GAP_CYC   (1),
        .IDX_WD    (IW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .scan_shift (scan_shift),
        .scan_sdi   (scan_sdi),
        .scan_sdo   (scan_sdo),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_data  (word_data),
        .word_idx   (word_idx),
        .word_last  (word_last)
    );

    // Repair-address source: slots shifted out LSB first, sdi written back per slot.
    logic [SW-1:0] src_init  [NW];
    logic [SW-1:0] src_words [NW];
    logic [1:0]    src_ptr;
    logic [3:0]    src_bit;
    logic [SW-1:0] src_shadow;
    logic          src_rst;

    assign scan_sdo = src_words[src_ptr][src_bit];

    always @(posedge clk) begin
        if (src_rst) begin
            for (int i = 0; i < NW; i++) src_words[i] <= src_init[i];
            src_ptr <= '0;
            src_bit <= '0;
        end else if (scan_shift) begin
            if (src_bit == 4'd15) begin
                src_words[src_ptr] <= {scan_sdi, src_shadow[14:0]};
                src_ptr <= src_ptr + 1'b1;
                src_bit <= '0;
            end else begin
                src_shadow[src_bit] <= scan_sdi;
                src_bit <= src_bit + 1'b1;
            end
        end
    end

    int            n_vec = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            rd_idx = 0;
    int            exp_n = 0;
    logic [RW-1:0] exp_data [NW];
    logic [RW-1:0] cap [NW];
    int            done_seen = 0;
    int            shift_cnt = 0;
    int            busy_cnt = 0;
    int            first_valid = -1;
    int            run = 0;
    bit            run_cut = 0;
    int            rdy_mode = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Per-cycle compare against the expected word list, sampled on the falling edge.
    task automatic cycle();
        @(negedge clk);
        cyc++;
        if (word_valid) begin
            if (first_valid < 0) first_valid = cyc;
            if (rd_idx >= exp_n) begin
                chk("spurious_word_valid", 32'(word_valid), 32'd0);
            end else begin
                chk("word_data", 32'(word_data), 32'(exp_data[rd_idx]));
                chk("word_idx",  32'(word_idx),  32'(rd_idx));
                chk("word_last", 32'(word_last), 32'(rd_idx == NW - 1));
            end
        end
        if (scan_shift) begin
            chk("scan_sdi_recirc", 32'(scan_sdi), 32'(scan_sdo));
            run++;
            shift_cnt++;
        end else begin
            if (run != 0 && !run_cut) chk("burst_len", 32'(run), 32'(SW));
            run = 0;
            run_cut = 0;
        end
        if (busy) busy_cnt++;
        if (done) done_seen++;
        if (word_valid && word_ready && rd_idx < NW) begin
            cap[rd_idx] = word_data;
            rd_idx++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        case (rdy_mode)
            0: word_ready = 1'b1;
            1: word_ready = ~word_ready;
            default: word_ready = 1'($urandom_range(0, 1));
        endcase
        cycle();
    endtask

    task automatic src_load(input logic [SW-1:0] w0, input logic [SW-1:0] w1,
                            input logic [SW-1:0] w2, input logic [SW-1:0] w3);
        src_init[0] = w0;
        src_init[1] = w1;
        src_init[2] = w2;
        src_init[3] = w3;
        src_rst = 1'b1;
        cycle();
        src_rst = 1'b0;
        for (int i = 0; i < NW; i++) exp_data[i] = src_init[i][RW-1:0];
        exp_n = NW;
        rd_idx = 0;
    endtask

    task automatic src_load_rand();
        src_load(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    endtask

    task automatic start_dump();
        first_valid = -1;
        busy_cnt = 0;
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0 = done_seen;
        int t = 0;
        while (done_seen == d0 && t < budget) begin
            step();
            t++;
        end
        chk("done_within_budget", 32'(t < budget), 32'd1);
        repeat (3) step();
        chk("done_pulse_count", 32'(done_seen - d0), 32'd1);
        chk("words_delivered", 32'(rd_idx), 32'(NW));
        chk("busy_after_done", 32'(busy), 32'd0);
    endtask

    task automatic check_src();
        for (int i = 0; i < NW; i++) chk("source_intact", 32'(src_words[i]), 32'(src_init[i]));
    endtask

    initial begin
        int s;
        int t;
        int d0;
        int s0;

        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        word_ready = 1'b0;
        src_rst = 1'b0;
        #1;
        src_load(16'h0, 16'h0, 16'h0, 16'h0);
        chk("rst_busy",       32'(busy),       32'd0);
        chk("rst_done",       32'(done),       32'd0);
        chk("rst_scan_shift", 32'(scan_shift), 32'd0);
        chk("rst_scan_sdi",   32'(scan_sdi),   32'd0);
        chk("rst_word_valid", 32'(word_valid), 32'd0);
        chk("rst_word_last",  32'(word_last),  32'd0);
        chk("rst_word_data",  32'(word_data),  32'd0);
        chk("rst_word_idx",   32'(word_idx),   32'd0);
        rst_n = 1'b1;
        cycle();

        // Directed dump with ready always high.
        src_load(16'h0012, 16'h01A5, 16'h00FF, 16'h0100);
        rdy_mode = 0;
        word_ready = 1'b1;
        start_dump();
        s = cyc;
        wait_done(200);
        chk("first_valid_latency", 32'(first_valid - s), 32'd18);
        chk("busy_cycles_full_dump", 32'(busy_cnt), 32'(NW * (1 + SW) + 2));
        chk("lit_word0", 32'(cap[0]), 32'h012);
        chk("lit_word1", 32'(cap[1]), 32'h1A5);
        chk("lit_word2", 32'(cap[2]), 32'h0FF);
        chk("lit_word3", 32'(cap[3]), 32'h100);
        check_src();

        // Consumer stalls on word 0: slot 1 completes then shifting stops.
        src_load_rand();
        word_ready = 1'b0;
        s0 = shift_cnt;
        start_dump();
        repeat (80) cycle();
        chk("hold_shift_cycles", 32'(shift_cnt - s0), 32'(2 * SW));
        chk("hold_word_valid", 32'(word_valid), 32'd1);
        chk("hold_scan_shift", 32'(scan_shift), 32'd0);
        rdy_mode = 0;
        wait_done(200);
        check_src();

        // Toggling and random backpressure with random slot contents.
        for (int it = 0; it < 6; it++) begin
            src_load_rand();
            rdy_mode = (it % 2 == 0) ? 1 : 2;
            start_dump();
            wait_done(600);
            check_src();
        end

        // Start pulsed while shifting slot 1 must not disturb the dump.
        src_load_rand();
        rdy_mode = 0;
        start_dump();
        t = 0;
        while (!(scan_shift && src_ptr == 2'd1) && t < 200) begin
            step();
            t++;
        end
        chk("reached_slot1_shift", 32'(t < 200), 32'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(200);
        check_src();

        // Abort at bit 7 of slot 2.
        src_load_rand();
        rdy_mode = 0;
        start_dump();
        t = 0;
        while (!(scan_shift && src_ptr == 2'd2 && src_bit == 4'd7) && t < 200) begin
            step();
            t++;
        end
        chk("reached_abort_point", 32'(t < 200), 32'd1);
        d0 = done_seen;
        abort = 1'b1;
        run_cut = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy",       32'(busy),       32'd0);
        chk("abort_word_valid", 32'(word_valid), 32'd0);
        chk("abort_scan_shift", 32'(scan_shift), 32'd0);
        exp_n = rd_idx;
        s0 = shift_cnt;
        repeat (20) step();
        chk("abort_no_done",  32'(done_seen - d0), 32'd0);
        chk("abort_no_shift", 32'(shift_cnt - s0), 32'd0);

        // Start and abort together while idle: abort wins.
        src_load_rand();
        s0 = shift_cnt;
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", 32'(busy), 32'd0);
        repeat (5) step();
        chk("start_abort_no_shift", 32'(shift_cnt - s0), 32'd0);

        // Asynchronous reset in the middle of a slot.
        src_load_rand();
        rdy_mode = 0;
        start_dump();
        t = 0;
        while (!(scan_shift && src_ptr == 2'd1 && src_bit == 4'd5) && t < 200) begin
            step();
            t++;
        end
        chk("reached_reset_point", 32'(t < 200), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy",       32'(busy),       32'd0);
        chk("arst_done",       32'(done),       32'd0);
        chk("arst_scan_shift", 32'(scan_shift), 32'd0);
        chk("arst_scan_sdi",   32'(scan_sdi),   32'd0);
        chk("arst_word_valid", 32'(word_valid), 32'd0);
        chk("arst_word_last",  32'(word_last),  32'd0);
        chk("arst_word_data",  32'(word_data),  32'd0);
        chk("arst_word_idx",   32'(word_idx),   32'd0);
        exp_n = rd_idx;
        run_cut = 1'b1;
        cycle();
        cycle();
        rst_n = 1'b1;

        // Fresh dump after reset recovers fully.
        src_load_rand();
        rdy_mode = 2;
        start_dump();
        wait_done(600);
        check_src();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
